// File: rtl/snake_vga_pkg.sv
// snake_vga_pkg: 640x480@60 timing, RRRGGGBB colour constants and helpers for the VGA front end.
package snake_vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int R_W = 3;
    localparam int G_W = 3;
    localparam int B_W = 2;
    localparam int COLOR_W = R_W + G_W + B_W;
    localparam logic [COLOR_W-1:0] BORDER = 8'b001_001_01;
    localparam logic [COLOR_W-1:0] BLACK = '0;
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic strobe;
    } raw_t;
    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++)
            if ((1 << r) >= v) return r;
        return 31;
    endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel strobe, raster counters, raw sync/active and the frame_start pulse.
module vga_timing
    import snake_vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_ACTIVE = snake_vga_pkg::H_ACTIVE,
    parameter int H_FP = snake_vga_pkg::H_FP,
    parameter int H_SYNC = snake_vga_pkg::H_SYNC,
    parameter int H_BP = snake_vga_pkg::H_BP,
    parameter int V_ACTIVE = snake_vga_pkg::V_ACTIVE,
    parameter int V_FP = snake_vga_pkg::V_FP,
    parameter int V_SYNC = snake_vga_pkg::V_SYNC,
    parameter int V_BP = snake_vga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       active,
    output logic       frame_start
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = CLK_DIV > 1 ? clog2(CLK_DIV) : 1;
    logic [DW-1:0] dcnt;
    logic h_end, v_end;
    assign pix_en = dcnt == '0;
    assign h_end = hcnt == 10'(HT - 1);
    assign v_end = vcnt == 10'(VT - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            dcnt <= (dcnt == DW'(CLK_DIV - 1)) ? '0 : dcnt + 1'b1;
            if (pix_en) begin
                hcnt <= h_end ? '0 : hcnt + 1'b1;
                if (h_end) vcnt <= v_end ? '0 : vcnt + 1'b1;
            end
        end
    end
    assign hs_raw = !(hcnt >= 10'(H_ACTIVE + H_FP) && hcnt < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw = !(vcnt >= 10'(V_ACTIVE + V_FP) && vcnt < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign active = hcnt < 10'(H_ACTIVE) && vcnt < 10'(V_ACTIVE);
    assign frame_start = pix_en && h_end && v_end;
endmodule

// File: rtl/snake_vga_frontend.sv
// snake_vga_frontend: VGA scan, evaluator-latency alignment to the DAC pins and the game tick divider.
module snake_vga_frontend
    import snake_vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_ACTIVE = snake_vga_pkg::H_ACTIVE,
    parameter int H_FP = snake_vga_pkg::H_FP,
    parameter int H_SYNC = snake_vga_pkg::H_SYNC,
    parameter int H_BP = snake_vga_pkg::H_BP,
    parameter int V_ACTIVE = snake_vga_pkg::V_ACTIVE,
    parameter int V_FP = snake_vga_pkg::V_FP,
    parameter int V_SYNC = snake_vga_pkg::V_SYNC,
    parameter int V_BP = snake_vga_pkg::V_BP,
    parameter int LATENCY = 2,
    parameter int FRAMES_PER_TICK = 6,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = BORDER
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               color_valid_in,
    output logic [9:0]         eval_x,
    output logic [9:0]         eval_y,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] rgb,
    output logic               frame_start,
    output logic               game_tick
);
    localparam int FW = FRAMES_PER_TICK > 1 ? clog2(FRAMES_PER_TICK) : 1;
    logic pix_en, pix_new, hs_raw, vs_raw, active, tick_frame;
    logic [FW-1:0] fcnt;
    raw_t dl [LATENCY];
    raw_t tap;
    vga_timing #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hcnt(eval_x), .vcnt(eval_y),
        .hs_raw(hs_raw), .vs_raw(vs_raw), .active(active), .frame_start(frame_start)
    );
    assign tap = dl[LATENCY-1];
    assign tick_frame = frame_start && run;
    assign game_tick = tick_frame && fcnt == FW'(FRAMES_PER_TICK - 1);
    // pix_new marks the first clk a new eval_x/eval_y is visible, so the tap lines up with color_in
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_new <= 1'b1;
            for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb <= BLACK;
            fcnt <= '0;
        end else begin
            pix_new <= pix_en;
            dl[0] <= '{hs: hs_raw, vs: vs_raw, active: active, strobe: pix_new};
            for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
            if (tap.strobe) begin
                hsync <= tap.hs;
                vsync <= tap.vs;
                rgb <= tap.active ? (color_valid_in ? color_in : BORDER_COLOR) : BLACK;
            end
            if (tick_frame) fcnt <= game_tick ? '0 : fcnt + 1'b1;
        end
    end
endmodule
